// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: redirect, instruction-memory and decode handshake signals of the fetch sequencer.
interface ifetch_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: one-at-a-time imem fetch sequencer feeding a 2-entry decode queue, with redirect flush.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    localparam logic [1:0] FULL = 2'(DEPTH);
    state_t      state;
    logic        req;
    logic [1:0]  count, cnt_pop, cnt_push;
    logic [31:0] fetch_pc, addr, rpc;
    logic [31:0] q_pc [2];
    logic [31:0] q_instr [2];
    logic        pop, ack;
    assign rpc      = bus.redirect_pc & ~32'd3;
    assign ack      = bus.imem_ack;
    assign pop      = (count != 2'd0) && bus.id_ready;
    assign cnt_pop  = count - {1'b0, pop};
    assign cnt_push = cnt_pop + 2'd1;
    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;
    assign bus.id_valid  = count != 2'd0;
    assign bus.id_pc     = q_pc[0];
    assign bus.id_instr  = q_instr[0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            count    <= 2'd0;
            fetch_pc <= RESET_PC;
            addr     <= RESET_PC;
            q_pc     <= '{default: 32'd0};
            q_instr  <= '{default: 32'd0};
        end else begin
            if (pop) begin
                q_pc[0]    <= q_pc[1];
                q_instr[0] <= q_instr[1];
            end
            if (bus.redirect_valid) begin
                // Flush queue; any in-flight word belongs to the old stream and is dropped.
                count    <= 2'd0;
                fetch_pc <= rpc;
                case (state)
                    IDLE: begin
                        state <= REQ;
                        req   <= 1'b1;
                        addr  <= rpc;
                    end
                    REQ: begin
                        if (ack) addr <= rpc;
                        else state <= DISCARD;
                    end
                    default: begin
                        if (ack) begin
                            state <= REQ;
                            addr  <= rpc;
                        end
                    end
                endcase
            end else begin
                count <= cnt_pop;
                case (state)
                    IDLE: begin
                        if (cnt_pop < FULL) begin
                            state <= REQ;
                            req   <= 1'b1;
                            addr  <= fetch_pc;
                        end
                    end
                    REQ: begin
                        if (ack) begin
                            q_pc[cnt_pop[0]]    <= addr;
                            q_instr[cnt_pop[0]] <= bus.imem_rdata;
                            count               <= cnt_push;
                            fetch_pc            <= addr + 32'd4;
                            if (cnt_push < FULL) addr <= addr + 32'd4;
                            else begin
                                state <= IDLE;
                                req   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        if (ack) begin
                            state <= REQ;
                            addr  <= fetch_pc;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed checks of fetch sequencing, backpressure, redirects, wrap and async reset.
module tb_ifetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    ifetch_ctrl_if bus ();
    ifetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    int lat = 0, wcnt = 0;
    bit man = 1'b0, man_ack = 1'b0, rdy = 1'b0, redir_v = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic [31:0] pop_pc [$];
    logic [31:0] pop_in [$];
    logic [31:0] ack_a [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, then drive the inputs seen at the following edge and log handshakes.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.redirect_valid = redir_v;
        bus.redirect_pc    = redir_pc;
        bus.id_ready       = rdy;
        bus.imem_rdata     = ~bus.imem_addr;
        if (man) bus.imem_ack = man_ack;
        else if (bus.imem_req && wcnt == lat) begin
            bus.imem_ack = 1'b1;
            wcnt = 0;
        end else begin
            bus.imem_ack = 1'b0;
            wcnt = bus.imem_req ? wcnt + 1 : 0;
        end
        if (bus.id_valid && bus.id_ready) begin
            pop_pc.push_back(bus.id_pc);
            pop_in.push_back(bus.id_instr);
        end
        if (bus.imem_req && bus.imem_ack) ack_a.push_back(bus.imem_addr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        man = 1'b0; man_ack = 1'b0; rdy = 1'b0; redir_v = 1'b0; redir_pc = 32'd0; wcnt = 0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0; bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0; bus.id_ready = 1'b0;
        tick();
        tick();
        pop_pc.delete(); pop_in.delete(); ack_a.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_pops(input int n, input logic [31:0] base);
        chk("pop_count", 32'(pop_pc.size()), 32'(n));
        for (int i = 0; i < n && i < pop_pc.size(); i++) begin
            chk("pop_pc", pop_pc[i], base + 32'(4 * i));
            chk("pop_instr", pop_in[i], ~(base + 32'(4 * i)));
        end
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_pc", bus.id_pc, 32'h0);
        chk("rst_instr", bus.id_instr, 32'h0);

        // Streaming with one wait cycle per request
        rdy = 1'b1; lat = 1;
        tick();
        chk("t1_first_req", 32'(bus.imem_req), 32'd1);
        chk("t1_first_addr", bus.imem_addr, 32'h0);
        repeat (11) tick();
        check_pops(5, 32'h0);
        chk("t1_acks", 32'(ack_a.size()), 32'd6);
        for (int i = 0; i < ack_a.size(); i++) chk("t1_ack_addr", ack_a[i], 32'(4 * i));

        // Backpressure fills the queue and stalls fetch
        do_reset();
        lat = 0;
        repeat (4) tick();
        chk("t2_req_stalled", 32'(bus.imem_req), 32'd0);
        chk("t2_valid", 32'(bus.id_valid), 32'd1);
        chk("t2_head_pc", bus.id_pc, 32'h0);
        chk("t2_head_instr", bus.id_instr, 32'hFFFF_FFFF);
        rdy = 1'b1;
        tick();
        tick();
        chk("t2_next_pc", bus.id_pc, 32'h4);
        chk("t2_next_addr", bus.imem_addr, 32'h8);
        chk("t2_req_resumed", 32'(bus.imem_req), 32'd1);
        check_pops(2, 32'h0);

        // Redirect during a slow request: old word discarded
        do_reset();
        man = 1'b1; rdy = 1'b1;
        tick();
        redir_v = 1'b1; redir_pc = 32'h100;
        tick();
        redir_v = 1'b0;
        tick();
        chk("t3_addr_held", bus.imem_addr, 32'h0);
        chk("t3_req_held", 32'(bus.imem_req), 32'd1);
        chk("t3_valid", 32'(bus.id_valid), 32'd0);
        tick();
        chk("t3_addr_held2", bus.imem_addr, 32'h0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t3_new_addr", bus.imem_addr, 32'h100);
        chk("t3_valid_after", 32'(bus.id_valid), 32'd0);
        tick();
        chk("t3_dropped", 32'(bus.id_valid), 32'd0);
        chk("t3_no_pops", 32'(pop_pc.size()), 32'd0);

        // Redirect coincident with ack and pop at count 1
        do_reset();
        man = 1'b1;
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t4_count1", 32'(bus.id_valid), 32'd1);
        chk("t4_inflight", bus.imem_addr, 32'h4);
        man_ack = 1'b1; rdy = 1'b1; redir_v = 1'b1; redir_pc = 32'h200;
        tick();
        man_ack = 1'b0; redir_v = 1'b0;
        tick();
        chk("t4_flushed", 32'(bus.id_valid), 32'd0);
        chk("t4_new_addr", bus.imem_addr, 32'h200);
        tick();
        chk("t4_word_dropped", 32'(bus.id_valid), 32'd0);

        // Unaligned redirect, then wrap past the top of memory
        do_reset();
        man = 1'b1;
        tick();
        redir_v = 1'b1; redir_pc = 32'h103;
        tick();
        redir_v = 1'b0;
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t5_aligned", bus.imem_addr, 32'h100);
        man_ack = 1'b1; redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        man_ack = 1'b0; redir_v = 1'b0;
        tick();
        chk("t5_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t5_wrap_addr", bus.imem_addr, 32'h0);
        chk("t5_top_pc", bus.id_pc, 32'hFFFF_FFFC);
        chk("t5_top_instr", bus.id_instr, 32'h3);

        // Asynchronous reset while a request is outstanding
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(bus.imem_req), 32'd0);
        chk("t6_valid_async", 32'(bus.id_valid), 32'd0);
        chk("t6_pc_async", bus.id_pc, 32'h0);
        tick();
        chk("t6_req_held", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_restart_req", 32'(bus.imem_req), 32'd1);
        chk("t6_restart_addr", bus.imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
